// File: rtl/v35_bus_bridge.sv
// V35 CPU to downstream bus bridge: one outstanding request per CPU strobe,
// with a bounded ACCESS phase that forces completion after TIMEOUT cycles.
module v35_bus_bridge #(
  parameter int          TIMEOUT = 255,
  parameter logic [15:0] RD_FILL = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] cpu_addr,
  input  logic        cpu_r_w,
  input  logic        cpu_n_ube,
  input  logic        cpu_n_mstb,
  input  logic        cpu_n_iostb,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_ready,
  output logic        bus_req,
  output logic        bus_io,
  output logic        bus_we,
  output logic [18:0] bus_addr,
  output logic [1:0]  bus_be,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_timeout
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [CW-1:0] r_cnt;
  logic        w_strobe;
  logic        w_start;
  logic        w_ack;
  logic        w_tmo;
  logic        r_io;
  logic        r_we;
  logic [18:0] r_addr;
  logic [1:0]  r_be;
  logic [15:0] r_wdata;
  logic [15:0] r_din;
  logic        r_timeout;

  assign w_strobe = ~cpu_n_mstb | ~cpu_n_iostb;
  assign w_start  = (r_state == S_IDLE) & w_strobe;
  assign w_ack    = (r_state == S_ACCESS) & bus_ack;
  // Ack on the final allowed cycle takes precedence over the forced completion.
  assign w_tmo    = (r_state == S_ACCESS) & ~bus_ack & (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_strobe) w_next = S_ACCESS;
      S_ACCESS: if (w_ack || w_tmo) w_next = S_DONE;
      S_DONE:   if (!w_strobe) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req   = (r_state == S_ACCESS);
    cpu_ready = ~(w_strobe & (r_state != S_DONE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_io      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_din     <= 16'h0000;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo;
      if (w_start) begin
        r_cnt   <= '0;
        r_io    <= cpu_n_mstb;  // memory strobe wins when both are low
        r_we    <= ~cpu_r_w;
        r_addr  <= cpu_addr[19:1];
        r_be    <= {~cpu_n_ube, ~cpu_addr[0]};
        r_wdata <= cpu_dout;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_ack && !r_we)      r_din <= bus_rdata;
      else if (w_tmo && !r_we) r_din <= RD_FILL;
    end
  end

  assign cpu_din     = r_din;
  assign bus_io      = r_io;
  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_be      = r_be;
  assign bus_wdata   = r_wdata;
  assign bus_timeout = r_timeout;

endmodule

// File: doc/v35_bus_bridge.md
V35_BUS_BRIDGE -- requirements
Module: v35_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum clk cycles spent in ACCESS before a forced completion.
REQ-002 Parameter RD_FILL, default 16'hFFFF: read data returned on a timed-out cycle.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_addr  input  20  CPU address A0-19.
REQ-006 cpu_r_w  input  1  1 = read, 0 = write.
REQ-007 cpu_n_ube  input  1  active-low upper byte enable.
REQ-008 cpu_n_mstb  input  1  active-low memory strobe.
REQ-009 cpu_n_iostb  input  1  active-low I/O strobe.
REQ-010 cpu_dout  input  16  CPU write data.
REQ-011 cpu_din  output  16  read data to CPU.
REQ-012 cpu_ready  output  1  CPU READY; 0 inserts wait states.
REQ-013 bus_req  output  1  downstream request, held until bus_ack.
REQ-014 bus_io  output  1  1 = I/O space, 0 = memory space.
REQ-015 bus_we  output  1  1 = write.
REQ-016 bus_addr  output  19  word address, cpu_addr[19:1].
REQ-017 bus_be  output  2  byte enables [1]=upper, [0]=lower.
REQ-018 bus_wdata  output  16  write data.
REQ-019 bus_rdata  input  16  read data, valid with bus_ack.
REQ-020 bus_ack  input  1  one-cycle completion pulse.
REQ-021 bus_timeout  output  1  one-cycle pulse on forced completion.

Function
REQ-022 FSM states: IDLE, ACCESS, DONE.
REQ-023 strobe = ~cpu_n_mstb | ~cpu_n_iostb.
REQ-024 IDLE -> ACCESS on the first clk edge with strobe = 1.
- Latch bus_io, bus_we, bus_addr, bus_be and bus_wdata on that edge.
- bus_req = 1 from the following cycle.
REQ-025 Space selection: if both strobes are low, memory wins (bus_io = 0).
REQ-026 Byte enables:
- bus_be[0] = ~cpu_addr[0].
- bus_be[1] = ~cpu_n_ube.
- bus_be = 2'b00 is still issued as a request.
REQ-027 bus_we = ~cpu_r_w.
REQ-028 Request attributes are held stable for the whole time bus_req = 1.
REQ-029 ACCESS -> DONE on the edge where bus_ack = 1.
- bus_req = 0 from the next cycle.
- On a read, bus_rdata is registered into cpu_din.
REQ-030 bus_ack outside ACCESS is ignored.
REQ-031 A cycle counter clears on entry to ACCESS and increments each cycle in ACCESS.
REQ-032 Timeout: counter reaching TIMEOUT without bus_ack forces ACCESS -> DONE.
- On a read, cpu_din = RD_FILL.
- bus_timeout pulses for one cycle.
- bus_req drops.
REQ-033 bus_ack and timeout on the same edge: bus_ack wins and bus_timeout stays 0.
REQ-034 cpu_ready = 0 (combinational) whenever strobe = 1 and the state is IDLE or ACCESS; otherwise 1.
REQ-035 DONE -> IDLE on the edge where strobe = 0.
- A strobe held low in DONE never starts a second request.
REQ-036 Strobe released during ACCESS (aborted cycle):
- The request still completes or times out.
- The FSM then passes through DONE to IDLE.
- cpu_din is updated normally.
REQ-037 cpu_din holds its last value until the next read completion; writes do not modify it.
REQ-038 Minimum latency: strobe sampled at edge N, bus_req high in cycle N+1; bus_ack at edge N+1 gives cpu_ready = 1 in cycle N+2.

Reset
REQ-039 Reset forces the following values immediately, independent of clk:
- FSM = IDLE, counter = 0.
- bus_req, bus_io, bus_we, bus_timeout = 0.
- bus_addr = 0, bus_be = 0, bus_wdata = 0.
- cpu_din = 16'h0000.
REQ-040 While reset is high, cpu_ready follows REQ-034 with state IDLE.
REQ-041 Reset asserted mid-ACCESS drops bus_req without waiting for bus_ack; a later bus_ack is ignored.
REQ-042 After reset release, a strobe already held low starts a new request on the first clk edge.

Verification
REQ-043 Memory read:
- Stimulus: cpu_addr=20'h12344, n_ube=0, n_mstb=0, r_w=1; bus_ack 3 cycles after bus_req with bus_rdata=16'hBEEF.
- Response: bus_addr=19'h091A2, bus_be=2'b11, cpu_ready=0 until cpu_din=16'hBEEF, then cpu_ready=1.
REQ-044 Odd-byte I/O write:
- Stimulus: cpu_addr=20'h00081, n_ube=0, n_iostb=0, r_w=0, cpu_dout=16'h5A00.
- Response: bus_io=1, bus_we=1, bus_be=2'b10, bus_wdata=16'h5A00; cpu_din unchanged.
REQ-045 Timeout:
- Stimulus: TIMEOUT=4, read, bus_ack never asserted.
- Response: bus_timeout pulses once, cpu_din=16'hFFFF, cpu_ready=1, bus_req=0.
REQ-046 Simultaneous ack and timeout:
- Stimulus: bus_ack on the timeout edge.
- Response: cpu_din=bus_rdata, bus_timeout=0.
REQ-047 Strobe held in DONE:
- Stimulus: strobe held low 10 cycles after ack.
- Response: exactly one bus_req pulse train; a second request occurs only after strobe goes high then low.
REQ-048 Reset mid-ACCESS:
- Stimulus: reset asserted during ACCESS.
- Response: bus_req=0 immediately; after release with strobe low, a new request is issued with freshly latched attributes.
